// File: rtl/bcd_xs3_pkg.sv
// -----------------------------------------------------------------------------
// bcd_xs3_pkg
//   Shared types and constants for the BCD -> Excess-3 sequencer.
//   xs3_state_t : sequencer FSM states
//   XS3_OFFSET  : Excess-3 bias added to every digit
//   BCD_MAX     : largest legal BCD digit
//   is_bcd()    : 1 when a 4-bit digit is a legal BCD value (0..9)
// -----------------------------------------------------------------------------
package bcd_xs3_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } xs3_state_t;

  localparam logic [3:0] XS3_OFFSET = 4'd3;
  localparam logic [3:0] BCD_MAX    = 4'd9;

  function automatic logic is_bcd(input logic [3:0] digit);
    return digit <= BCD_MAX;
  endfunction

endpackage

// File: rtl/bcd_xs3_seq_ctrl_if.sv
// -----------------------------------------------------------------------------
// bcd_xs3_seq_ctrl_if
//   Valid/ready bundle for the BCD -> Excess-3 sequencer.
//   in_valid/in_ready/in_bcd    : producer side, one packed BCD word
//   out_valid/out_ready/out_xs3 : consumer side, one packed Excess-3 word
//   master : the surrounding system (drives in_valid, in_bcd, out_ready)
//   slave  : the sequencer (drives in_ready, out_valid, out_xs3)
// -----------------------------------------------------------------------------
interface bcd_xs3_seq_ctrl_if #(
  parameter int NDIGITS = 4
);

  logic                   in_valid;
  logic                   in_ready;
  logic [4*NDIGITS-1:0]   in_bcd;
  logic                   out_valid;
  logic                   out_ready;
  logic [4*NDIGITS-1:0]   out_xs3;

  modport master (
    output in_valid, in_bcd, out_ready,
    input  in_ready, out_valid, out_xs3
  );

  modport slave (
    input  in_valid, in_bcd, out_ready,
    output in_ready, out_valid, out_xs3
  );

endinterface

// File: rtl/bcd_xs3_digit.sv
// -----------------------------------------------------------------------------
// bcd_xs3_digit
//   Combinational single-digit Excess-3 converter, enable gated.
//   in  [3:0] : BCD digit
//   enb       : 1 = convert, 0 = force output to zero
//   out [3:0] : in + 3 (modulo 16) when enabled, else 0
// -----------------------------------------------------------------------------
module bcd_xs3_digit
  import bcd_xs3_pkg::*;
(
  input  logic [3:0] in,
  input  logic       enb,
  output logic [3:0] out
);

  // 4-bit add wraps on purpose: illegal digits 10..15 map to 13,14,15,0,1,2.
  assign out = enb ? (in + XS3_OFFSET) : 4'd0;

endmodule

// File: rtl/bcd_xs3_seq_ctrl.sv
// -----------------------------------------------------------------------------
// bcd_xs3_seq_ctrl
//   Converts a packed NDIGITS-digit BCD word to Excess-3, one digit per clock,
//   time-sharing a single bcd_xs3_digit converter.
//   clk    : system clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : bcd_xs3_seq_ctrl_if.slave (in_valid/in_ready/in_bcd,
//            out_valid/out_ready/out_xs3)
//   busy   : high while a word is in flight (CONV or DONE)
//   err    : only with BCD_XS3_DIGIT_CHECK_EN defined; set when the captured
//            word holds a digit above 9, cleared on the next accept
//   Optional feature macro: BCD_XS3_DIGIT_CHECK_EN
// -----------------------------------------------------------------------------
module bcd_xs3_seq_ctrl
  import bcd_xs3_pkg::*;
#(
  parameter int NDIGITS = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  bcd_xs3_seq_ctrl_if.slave    bus,
`ifdef BCD_XS3_DIGIT_CHECK_EN
  output logic                 busy,
  output logic                 err
`else
  output logic                 busy
`endif
);

  // Keep a 1-bit index even for a single-digit build.
  localparam int                IDX_W    = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NDIGITS - 1);

  xs3_state_t                  state, state_nxt;
  logic [IDX_W-1:0]            idx;
  logic [NDIGITS-1:0][3:0]     hold_q;
  logic [NDIGITS-1:0][3:0]     xs3_q;
  logic [3:0]                  cur_digit;
  logic [3:0]                  conv_out;
  logic                        conv_en;
  logic                        accept;
  logic                        last_digit;

  assign accept     = bus.in_valid && (state == IDLE);
  assign last_digit = (idx == LAST_IDX);
  assign cur_digit  = hold_q[idx];
  assign bus.out_xs3 = xs3_q;

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // ---------------------------------------------------------------------------
  // FSM next state and decoded outputs
  // ---------------------------------------------------------------------------
  // NOTE: every output of this block is given a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_nxt     = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    busy          = 1'b0;
    conv_en       = 1'b0;
    case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) state_nxt = CONV;
      end
      CONV: begin
        busy    = 1'b1;
        conv_en = 1'b1;
        if (last_digit) state_nxt = DONE;
      end
      DONE: begin
        busy          = 1'b1;
        bus.out_valid = 1'b1;
        // in_ready stays low here: no accept on the DONE->IDLE edge.
        if (bus.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Shared digit converter
  // ---------------------------------------------------------------------------
  bcd_xs3_digit u_digit (
    .in  (cur_digit),
    .enb (conv_en),
    .out (conv_out)
  );

  // ---------------------------------------------------------------------------
  // Datapath: capture, digit index, result slots
  // ---------------------------------------------------------------------------
  // NOTE: the holding and result registers are reset as well; the result is a
  // visible output that must read zero after reset, and both are small.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx    <= '0;
      hold_q <= '0;
      xs3_q  <= '0;
    end else if (accept) begin
      hold_q <= bus.in_bcd;
      idx    <= '0;
    end else if (state == CONV) begin
      xs3_q[idx] <= conv_out;
      idx        <= last_digit ? '0 : idx + 1'b1;
    end
  end

`ifdef BCD_XS3_DIGIT_CHECK_EN
  // ---------------------------------------------------------------------------
  // Illegal-digit flag: sticky across the word, cleared by the next accept.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                 err <= 1'b0;
    else if (accept)                            err <= 1'b0;
    else if (state == CONV && !is_bcd(cur_digit)) err <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_bcd_xs3_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_bcd_xs3_seq_ctrl
//   Directed bench for bcd_xs3_seq_ctrl with NDIGITS = 4. Inputs are driven and
//   outputs sampled on the falling clock edge.
//   Optional feature macro: BCD_XS3_DIGIT_CHECK_EN
// -----------------------------------------------------------------------------
module tb_bcd_xs3_seq_ctrl;

  localparam int NDIGITS = 4;

  logic clk;
  logic rst_n;
  logic busy;
`ifdef BCD_XS3_DIGIT_CHECK_EN
  logic err;
`endif

  int errors = 0;
  int checks = 0;

  bcd_xs3_seq_ctrl_if #(.NDIGITS(NDIGITS)) bus ();

  bcd_xs3_seq_ctrl #(.NDIGITS(NDIGITS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
`ifdef BCD_XS3_DIGIT_CHECK_EN
    .busy  (busy),
    .err   (err)
`else
    .busy  (busy)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, required finish before 200000");
    $fatal(1, "timeout");
  end

  typedef struct {
    string       name;
    logic [15:0] bcd;
    logic [15:0] xs3;
    logic        err;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, got, exp);
    end
  endtask

  // Wait (bounded) at falling edges until the block can accept.
  task automatic wait_ready();
    int n = 0;
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_wait", bus.in_ready, 1'b1);
  endtask

  // Offer one word; returns at the falling edge right after the accept edge.
  task automatic send(input logic [15:0] bcd);
    wait_ready();
    bus.in_valid = 1'b1;
    bus.in_bcd   = bcd;
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  // Count rising edges (bounded) until out_valid is seen.
  task automatic wait_valid(output int n);
    n = 0;
    while (!bus.out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic run_vec(input vec_t v);
    int n;
    bus.out_ready = 1'b1;
    send(v.bcd);
    wait_valid(n);
    check({v.name, "_latency"}, n, NDIGITS);
    check({v.name, "_xs3"}, bus.out_xs3, v.xs3);
`ifdef BCD_XS3_DIGIT_CHECK_EN
    check({v.name, "_err"}, err, v.err);
`endif
    @(negedge clk);
    check({v.name, "_valid_one_cycle"}, bus.out_valid, 1'b0);
    check({v.name, "_back_idle"}, bus.in_ready, 1'b1);
`ifdef BCD_XS3_DIGIT_CHECK_EN
    check({v.name, "_err_hold"}, err, v.err);
`endif
  endtask

  initial begin
    int          n;
    int          cyc;
    int          t0;
    int          t1;
    logic        got0;
    logic [15:0] r0;
    vec_t        v;

    vecs[0] = '{"basic_1234",   16'h1234, 16'h4567, 1'b0};
    vecs[1] = '{"zero_0000",    16'h0000, 16'h3333, 1'b0};
    vecs[2] = '{"max_9999",     16'h9999, 16'hCCCC, 1'b0};
    vecs[3] = '{"illegal_12a4", 16'h12A4, 16'h45D7, 1'b1};
    vecs[4] = '{"clear_0001",   16'h0001, 16'h3334, 1'b0};
    vecs[5] = '{"mixed_0505",   16'h0505, 16'h3838, 1'b0};

    bus.in_valid  = 1'b0;
    bus.in_bcd    = '0;
    bus.out_ready = 1'b0;
    rst_n         = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state
    check("rst_in_ready",  bus.in_ready,  1'b1);
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_busy",      busy,          1'b0);
    check("rst_out_xs3",   bus.out_xs3,   16'h0000);
`ifdef BCD_XS3_DIGIT_CHECK_EN
    check("rst_err",       err,           1'b0);
`endif
    rst_n = 1'b1;
    @(negedge clk);

    // Table-driven words
    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Back-to-back with in_valid held: accepts 6 cycles apart, second word
    // presented only after the first is taken.
    bus.out_ready = 1'b1;
    wait_ready();
    bus.in_valid = 1'b1;
    bus.in_bcd   = 16'h1234;
    cyc  = 0;
    t0   = -1;
    t1   = -1;
    got0 = 1'b0;
    r0   = '0;
    while (t1 < 0 && cyc < 30) begin
      if (bus.in_ready) begin
        if (t0 < 0) t0 = cyc;
        else        t1 = cyc;
      end
      @(negedge clk);
      cyc++;
      if (t0 >= 0 && t1 < 0) bus.in_bcd = 16'h0505;
      if (bus.out_valid && !got0) begin
        r0   = bus.out_xs3;
        got0 = 1'b1;
      end
    end
    bus.in_valid = 1'b0;
    check("b2b_accept_gap", t1 - t0, 6);
    check("b2b_first_xs3",  r0,      16'h4567);
    wait_valid(n);
    check("b2b_second_latency", n, NDIGITS);
    check("b2b_second_xs3", bus.out_xs3, 16'h3838);
    @(negedge clk);

    // Backpressure: hold DONE for 5 cycles
    bus.out_ready = 1'b0;
    send(16'h1234);
    wait_valid(n);
    check("bp_latency", n, NDIGITS);
    for (int i = 0; i < 5; i++) begin
      check("bp_out_valid", bus.out_valid, 1'b1);
      check("bp_out_xs3",   bus.out_xs3,   16'h4567);
      check("bp_in_ready",  bus.in_ready,  1'b0);
      check("bp_busy",      busy,          1'b1);
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_idle", bus.in_ready,  1'b1);
    check("bp_release_busy", busy,          1'b0);
    check("bp_release_vld",  bus.out_valid, 1'b0);

    // Input changes during CONV are ignored
    send(16'h1234);
    bus.in_bcd   = 16'h8888;
    bus.in_valid = 1'b1;
    repeat (2) @(negedge clk);
    bus.in_valid = 1'b0;
    wait_valid(n);
    check("ignore_valid", bus.out_valid, 1'b1);
    check("ignore_xs3",   bus.out_xs3,   16'h4567);
    @(negedge clk);

    // Reset mid-CONV at digit index 2
    send(16'h1234);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", bus.out_valid, 1'b0);
    check("midrst_busy",      busy,          1'b0);
    check("midrst_in_ready",  bus.in_ready,  1'b1);
    check("midrst_out_xs3",   bus.out_xs3,   16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", bus.in_ready, 1'b1);
    v = '{"post_rst_0505", 16'h0505, 16'h3838, 1'b0};
    run_vec(v);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
